// File: rtl/bus_arbiter_pkg.sv
// Shared bus types plus the arbiter state encoding and the timeout read-data marker.
package bus_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  localparam word_t BUS_TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req scanning last+1, last+2, ... modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);
  int idx;

  always_comb begin
    pick = '0;
    any  = |req;
    idx  = 0;
    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) pick = IW'(idx);
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus among N_MASTERS; grant registered one cycle ahead of issue.
// Optional watchdog enabled by BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic     [N_MASTERS-1:0]  m_valid,
  input  word_t    [N_MASTERS-1:0]  m_address,
  input  wstrobe_t [N_MASTERS-1:0]  m_wstrobe,
  input  word_t    [N_MASTERS-1:0]  m_wdata,
  output logic     [N_MASTERS-1:0]  m_ready,
  output word_t    [N_MASTERS-1:0]  m_rdata,
  output logic     [N_MASTERS-1:0]  m_irq,
  output logic                      s_valid,
  output word_t                     s_address,
  output wstrobe_t                  s_wstrobe,
  output word_t                     s_wdata,
  input  logic                      s_ready,
  input  word_t                     s_rdata,
`ifdef BUS_ARBITER_TIMEOUT_EN
  input  logic                      s_irq,
  output logic                      timeout
`else
  input  logic                      s_irq
`endif
);
  localparam int IW = $clog2(N_MASTERS);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          expired;

  rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
    .req  (m_valid),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Counter holds the number of completed wait cycles, so expiry lands on BUSY cycle TIMEOUT_CYCLES.
  assign expired = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  assign m_irq = {N_MASTERS{s_irq}};

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    s_valid   = 1'b0;
    s_address = '0;
    s_wstrobe = '0;
    s_wdata   = '0;
    m_ready   = '0;
    m_rdata   = {N_MASTERS{s_rdata}};
`ifdef BUS_ARBITER_TIMEOUT_EN
    timeout   = 1'b0;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          g_d     = pick;
          state_d = BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        s_valid   = m_valid[g_q];
        s_address = m_address[g_q];
        s_wstrobe = m_wstrobe[g_q];
        s_wdata   = m_wdata[g_q];
        if (expired) begin
          // Slave is abandoned: complete the master with a marker value and ignore any late ready.
          s_valid      = 1'b0;
          m_ready[g_q] = 1'b1;
          m_rdata[g_q] = BUS_TIMEOUT_RDATA;
`ifdef BUS_ARBITER_TIMEOUT_EN
          timeout      = 1'b1;
`endif
          last_d       = g_q;
          state_d      = IDLE;
        end else if (s_valid && s_ready) begin
          m_ready[g_q] = 1'b1;
          last_d       = g_q;
          state_d      = IDLE;
        end else if (!m_valid[g_q]) begin
          state_d = IDLE;
        end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IW'(N_MASTERS - 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random bench for bus_arbiter against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int NM = 2;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NM-1:0]        m_valid;
  logic [NM-1:0][31:0]  m_address;
  logic [NM-1:0][3:0]   m_wstrobe;
  logic [NM-1:0][31:0]  m_wdata;
  logic [NM-1:0]        m_ready;
  logic [NM-1:0][31:0]  m_rdata;
  logic [NM-1:0]        m_irq;
  logic                 s_valid;
  logic [31:0]          s_address;
  logic [3:0]           s_wstrobe;
  logic [31:0]          s_wdata;
  logic                 s_ready;
  logic [31:0]          s_rdata;
  logic                 s_irq;
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic                 timeout;
`endif

  bus_arbiter #(.N_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wstrobe (m_wstrobe),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_irq     (m_irq),
    .s_valid   (s_valid),
    .s_address (s_address),
    .s_wstrobe (s_wstrobe),
    .s_wdata   (s_wdata),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
`ifdef BUS_ARBITER_TIMEOUT_EN
    .s_irq     (s_irq),
    .timeout   (timeout)
`else
    .s_irq     (s_irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (if anyone), who was served last, how long the owner has waited.
  bit          busy;
  int          owner;
  int          last_served;
  int          waited;
  logic [NM-1:0] done;
  int          grants[$];
  int          to_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_expired();
`ifdef BUS_ARBITER_TIMEOUT_EN
    return busy && (waited == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Compare every DUT output against what the model predicts for the current inputs.
  task automatic settle();
    bit            exp_to;
    bit            exp_sv;
    logic [NM-1:0] exp_rdy;
    logic [31:0]   exp_rd;
    #1;
    exp_to  = model_expired();
    exp_sv  = busy && m_valid[owner] && !exp_to;
    exp_rdy = '0;
    if (busy && (exp_to || (exp_sv && s_ready))) exp_rdy[owner] = 1'b1;
    chk("s_valid", 32'(s_valid), 32'(exp_sv));
    chk("m_ready", 32'(m_ready), 32'(exp_rdy));
    chk("s_address", s_address, busy ? m_address[owner] : 32'h0);
    chk("s_wstrobe", 32'(s_wstrobe), busy ? 32'(m_wstrobe[owner]) : 32'h0);
    chk("s_wdata", s_wdata, busy ? m_wdata[owner] : 32'h0);
    chk("m_irq", 32'(m_irq), s_irq ? 32'h3 : 32'h0);
    for (int i = 0; i < NM; i++) begin
      exp_rd = (exp_to && i == owner) ? 32'hDEADBEEF : s_rdata;
      chk("m_rdata", m_rdata[i], exp_rd);
    end
`ifdef BUS_ARBITER_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(exp_to));
    if (timeout === 1'b1) to_pulses++;
`endif
    done = exp_rdy;
  endtask

  // Advance one clock and apply the arbitration rules to the model.
  task automatic tick();
    bit exp_to;
    exp_to = model_expired();
    @(posedge clk);
    if (reset) begin
      busy = 0; last_served = NM - 1; waited = 0;
    end else if (!busy) begin
      for (int k = 1; k <= NM; k++) begin
        if (!busy && m_valid[(last_served + k) % NM]) begin
          owner = (last_served + k) % NM; busy = 1; waited = 0;
        end
      end
    end else if (exp_to || (m_valid[owner] && s_ready)) begin
      last_served = owner; busy = 0;
    end else if (!m_valid[owner]) begin
      busy = 0;
    end else begin
      waited++;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; m_valid = '0; m_address = '0; m_wstrobe = '0; m_wdata = '0;
    s_ready = 0; s_rdata = '0; s_irq = 0;
    busy = 0; owner = 0; last_served = NM - 1; waited = 0; done = '0; to_pulses = 0;
    @(negedge clk);
    tick(); tick();
    settle();
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    reset = 0;

    // Single read by master 0 with a zero-wait slave.
    m_valid = 2'b01; m_address[0] = 32'h100; s_ready = 1; s_rdata = 32'h12345678;
    settle();
    chk("t1_idle_s_valid", 32'(s_valid), 32'h0);
    tick();
    settle();
    chk("t1_busy_s_valid", 32'(s_valid), 32'h1);
    chk("t1_m_ready", 32'(m_ready), 32'h1);
    chk("t1_m_rdata0", m_rdata[0], 32'h12345678);
    tick();
    m_valid = '0;
    settle(); tick();

    // Both masters continuously requesting after reset: grants alternate starting at master 0.
    reset = 1; settle(); tick(); reset = 0;
    m_valid = 2'b11; m_address[1] = 32'h200;
    for (int c = 0; c < 8; c++) begin
      settle();
      for (int i = 0; i < NM; i++) if (m_ready[i]) grants.push_back(i);
      tick();
    end
    chk("t2_grant_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++) chk("t2_grant_order", 32'(grants[k]), 32'(k % 2));
    m_valid = '0;
    settle(); tick();

    // Master 1 write with three slave wait states.
    m_valid = 2'b10; m_wdata[1] = 32'hCAFEF00D; m_wstrobe[1] = 4'b0011; s_ready = 0;
    settle(); tick();
    for (int k = 0; k < 4; k++) begin
      s_ready = (k == 3);
      settle();
      chk("t3_wstrobe", 32'(s_wstrobe), 32'h3);
      chk("t3_wdata", s_wdata, 32'hCAFEF00D);
      chk("t3_m_ready", 32'(m_ready), (k == 3) ? 32'h2 : 32'h0);
      tick();
    end
    m_valid = '0; s_ready = 0;
    settle(); tick();

    // Reset while master 1 is mid-transfer, then both request: master 0 wins.
    m_valid = 2'b10;
    settle(); tick();
    settle(); tick();
    reset = 1;
    settle(); tick();
    reset = 0; m_valid = 2'b11;
    settle();
    chk("t4_post_rst_s_valid", 32'(s_valid), 32'h0);
    chk("t4_post_rst_m_ready", 32'(m_ready), 32'h0);
    tick();
    s_ready = 1;
    settle();
    chk("t4_first_grant", 32'(m_ready), 32'h1);
    tick();
    settle(); tick();
    settle();
    chk("t4_second_grant", 32'(m_ready), 32'h2);
    tick();
    m_valid = '0;

    // Interrupt passthrough while idle and while busy.
    s_irq = 1; settle(); chk("t5_irq_idle", 32'(m_irq), 32'h3);
    s_irq = 0; settle(); chk("t5_irq_idle_low", 32'(m_irq), 32'h0);
    m_valid = 2'b01; s_ready = 0; tick();
    s_irq = 1; settle(); chk("t5_irq_busy", 32'(m_irq), 32'h3);
    s_ready = 1; tick();
    m_valid = '0; s_irq = 0; settle(); tick();

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Unresponsive slave: expiry on the fourth BUSY cycle, then master 1 is served.
    reset = 1; settle(); tick(); reset = 0;
    m_valid = 2'b11; s_ready = 0; to_pulses = 0;
    settle(); tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t6_to_m_ready", 32'(m_ready), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) chk("t6_to_rdata", m_rdata[0], 32'hDEADBEEF);
      tick();
    end
    m_valid = 2'b10;
    s_ready = 1;
    settle(); tick();
    settle();
    chk("t6_next_grant", 32'(m_ready), 32'h2);
    chk("t6_to_pulses", 32'(to_pulses), 32'd1);
    tick();
    m_valid = '0; s_ready = 0;
    settle(); tick();
`endif

    // Random traffic; masters hold requests until served.
    for (int c = 0; c < 400; c++) begin
      s_ready = ($urandom_range(0, 2) != 0);
      s_rdata = $urandom;
      s_irq   = $urandom_range(0, 1);
      settle();
      tick();
      for (int i = 0; i < NM; i++) begin
        if (done[i] || !m_valid[i]) begin
          m_valid[i]   = $urandom_range(0, 1);
          m_address[i] = $urandom;
          m_wstrobe[i] = 4'($urandom);
          m_wdata[i]   = $urandom;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
